// File: rtl/dataflow_model.sv
// Autonomous 8-state Gray-code Moore sequencer producing the serial pattern 0,0,1,0,1,1,0,1.
// Next state is written as explicit sum-of-products equations over the current state bits.
module dataflow_model (
    input  logic clk,
    input  logic reset,
    output logic y
);

    logic [2:0] state_q;
    logic [2:0] state_d;

    logic q2;
    logic q1;
    logic q0;

    assign q2 = state_q[2];
    assign q1 = state_q[1];
    assign q0 = state_q[0];

    // Product terms of the next-state equations.
    logic d2_p0;
    logic d2_p1;
    logic d1_p0;
    logic d1_p1;
    logic d0_p0;
    logic d0_p1;

    assign d2_p0 = q1 & ~q0;
    assign d2_p1 = q2 & q0;
    assign d1_p0 = ~q2 & q0;
    assign d1_p1 = q1 & ~q0;
    assign d0_p0 = ~q2 & ~q1;
    assign d0_p1 = q2 & q1;

    always_comb begin
        state_d    = 3'b000;
        state_d[2] = d2_p0 | d2_p1;
        state_d[1] = d1_p0 | d1_p1;
        state_d[0] = d0_p0 | d0_p1;
    end

    // Every 3-bit code lies on the cycle, so no recovery path is needed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= 3'b000;
        end else begin
            state_q <= state_d;
        end
    end

    // y is high in states 011, 110, 111 and 100.
    always_comb begin
        y = (q2 & ~q0) | (q1 & q0);
    end

endmodule

// File: tb/tb_dataflow_model.sv
// Directed self-checking bench for dataflow_model: reset, sequence, wrap, async reset
// mid-run, Gray stepping and reset release coincident with a rising edge.
module tb_dataflow_model;

    logic clk;
    logic reset;
    logic y;

    int n_checks;
    int n_fail;

    logic [2:0] exp_q [8];
    logic       exp_y [8];
    logic [2:0] prev_q;

    dataflow_model dut (
        .clk   (clk),
        .reset (reset),
        .y     (y)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and compare against table entry idx (state after the edge).
    task automatic run_step(input string tag, input int idx);
        prev_q = dut.state_q;
        @(posedge clk);
        #1;
        check_eq({tag, "_q"}, {29'd0, dut.state_q}, {29'd0, exp_q[idx]});
        check_eq({tag, "_y"}, {31'd0, y}, {31'd0, exp_y[idx]});
        check_eq({tag, "_gray"}, $countones(dut.state_q ^ prev_q), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        // State and y after edges 1..8 following reset release.
        exp_q[0] = 3'b001; exp_y[0] = 1'b0;
        exp_q[1] = 3'b011; exp_y[1] = 1'b1;
        exp_q[2] = 3'b010; exp_y[2] = 1'b0;
        exp_q[3] = 3'b110; exp_y[3] = 1'b1;
        exp_q[4] = 3'b111; exp_y[4] = 1'b1;
        exp_q[5] = 3'b101; exp_y[5] = 1'b0;
        exp_q[6] = 3'b100; exp_y[6] = 1'b1;
        exp_q[7] = 3'b000; exp_y[7] = 1'b0;

        // 1. Reset held across 3 edges.
        reset = 1'b0;
        #1;
        check_eq("rst_init_q", {29'd0, dut.state_q}, 32'd0);
        check_eq("rst_init_y", {31'd0, y}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_hold_q", {29'd0, dut.state_q}, 32'd0);
            check_eq("rst_hold_y", {31'd0, y}, 32'd0);
        end

        // 2. Release between edges, one full period.
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) run_step("seq", i);

        // 3. Two more periods: wrap with no dead cycle.
        for (int i = 0; i < 16; i++) run_step("wrap", i % 8);

        // 4. Async reset mid-cycle while Q=111.
        for (int i = 0; i < 5; i++) run_step("pre_rst", i);
        check_eq("at_111_q", {29'd0, dut.state_q}, 32'd7);
        #5;
        reset = 1'b0;
        #1;
        check_eq("async_rst_q", {29'd0, dut.state_q}, 32'd0);
        check_eq("async_rst_y", {31'd0, y}, 32'd0);
        @(negedge clk);
        check_eq("async_hold_q", {29'd0, dut.state_q}, 32'd0);
        reset = 1'b1;
        run_step("restart", 0);
        run_step("restart", 1);

        // 6. Release coincident with a rising edge: that edge must be ignored.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("coinc_rst_q", {29'd0, dut.state_q}, 32'd0);
        @(posedge clk);
        // Nonblocking so the release lands after the flop has seen this edge with reset low.
        reset <= 1'b1;
        #1;
        check_eq("coinc_edge_q", {29'd0, dut.state_q}, 32'd0);
        check_eq("coinc_edge_y", {31'd0, y}, 32'd0);
        check_eq("coinc_rel", {31'd0, reset}, 32'd1);
        run_step("coinc_next", 0);
        run_step("coinc_next", 1);
        run_step("coinc_next", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
